// File: rtl/write_fifo.sv
// Producer side of a FIFO test pair: resets the FIFO write side, then writes
// bursts of a wrapping incrementing pattern with empty/full hysteresis.
module write_fifo #(
  parameter logic [7:0]  start            = 8'd0,
  parameter logic [7:0]  stop             = 8'd255,
  parameter int unsigned cnt_to_light_led = 102400,
  parameter int unsigned wrst_cycles      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              full_flag,
  input  logic              empty_flag,
  output logic              we,
  output logic              wrst,
  output logic signed [7:0] wr_data,
  output logic [7:0]        burst_cnt,
  output logic [3:0]        cnt_leds,
  output logic [7:0]        rej_cnt
);

  localparam int RC_W = (wrst_cycles < 1) ? 1 : $clog2(wrst_cycles + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(wrst_cycles);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [23:0]     WC_LAST = 24'(cnt_to_light_led - 1);

  typedef enum logic [1:0] {
    S_RST,
    S_IDLE,
    S_FILL
  } state_t;

  state_t          state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            we_q, we_d;
  logic            wrst_q, wrst_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      burst_q, burst_d;
  logic [3:0]      leds_q, leds_d;
  logic [7:0]      rej_q, rej_d;
  logic [23:0]     wc_q, wc_d;

  logic accept;
  logic reject;

  // The FIFO only consumes a word when it is not full; a full cycle is a reject.
  assign accept = we_q & ~full_flag;
  assign reject = we_q & full_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      rc_q    <= '0;
      we_q    <= 1'b0;
      wrst_q  <= 1'b1;
      data_q  <= start;
      burst_q <= '0;
      leds_q  <= '0;
      rej_q   <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      we_q    <= we_d;
      wrst_q  <= wrst_d;
      data_q  <= data_d;
      burst_q <= burst_d;
      leds_q  <= leds_d;
      rej_q   <= rej_d;
      wc_q    <= wc_d;
    end
  end

  // Datapath: pattern, LED block counter and saturating reject counter.
  always_comb begin
    data_d = data_q;
    wc_d   = wc_q;
    leds_d = leds_q;
    rej_d  = rej_q;
    if (accept) begin
      data_d = (data_q == stop) ? start : data_q + 8'd1;
      if (wc_q == WC_LAST) begin
        wc_d   = '0;
        leds_d = leds_q + 4'd1;
      end else begin
        wc_d = wc_q + 24'd1;
      end
    end
    if (reject && (rej_q != 8'hFF)) begin
      rej_d = rej_q + 8'd1;
    end
  end

  // Control FSM; we/wrst are computed here and registered with the state.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    we_d    = 1'b0;
    wrst_d  = 1'b0;
    burst_d = burst_q;
    unique case (state_q)
      S_RST: begin
        wrst_d = 1'b1;
        if (rc_q == RC_LAST) begin
          state_d = S_IDLE;
          wrst_d  = 1'b0;
        end else begin
          rc_d = rc_q + RC_ONE;
        end
      end
      S_IDLE: begin
        // Full wins over empty, so a FIFO reporting both never starts a burst.
        if (en && empty_flag && !full_flag) begin
          state_d = S_FILL;
          we_d    = 1'b1;
          burst_d = burst_q + 8'd1;
        end
      end
      S_FILL: begin
        we_d = 1'b1;
        if (full_flag || !en) begin
          state_d = S_IDLE;
          we_d    = 1'b0;
        end
      end
      default: begin
        state_d = S_RST;
        rc_d    = '0;
        wrst_d  = 1'b1;
      end
    endcase
  end

  assign we        = we_q;
  assign wrst      = wrst_q;
  assign wr_data   = data_q;
  assign burst_cnt = burst_q;
  assign cnt_leds  = leds_q;
  assign rej_cnt   = rej_q;

endmodule

// File: tb/tb_write_fifo.sv
// Directed bench for write_fifo: two instances (default pattern and a wrapping
// 250..255 pattern) are checked every clock against a reference model.
module tb_write_fifo;

  localparam int WC  = 4;
  localparam int CNT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, full_flag, empty_flag;
  logic we_a, wrst_a, we_b, wrst_b;
  logic [7:0] wr_data_a, wr_data_b, burst_a, burst_b, rej_a, rej_b;
  logic [3:0] leds_a, leds_b;

  write_fifo #(.start(8'd0), .stop(8'd255), .cnt_to_light_led(CNT), .wrst_cycles(WC)) dut_a (
    .clk(clk), .rst(rst), .en(en), .full_flag(full_flag), .empty_flag(empty_flag),
    .we(we_a), .wrst(wrst_a), .wr_data(wr_data_a), .burst_cnt(burst_a),
    .cnt_leds(leds_a), .rej_cnt(rej_a));

  write_fifo #(.start(8'd250), .stop(8'd255), .cnt_to_light_led(CNT), .wrst_cycles(WC)) dut_b (
    .clk(clk), .rst(rst), .en(en), .full_flag(full_flag), .empty_flag(empty_flag),
    .we(we_b), .wrst(wrst_b), .wr_data(wr_data_b), .burst_cnt(burst_b),
    .cnt_leds(leds_b), .rej_cnt(rej_b));

  int nvec  = 0;
  int nfail = 0;

  // Reference model state
  int         m_st = 0;  // 0 reset, 1 idle, 2 fill
  int         m_rc = 0;
  logic       m_we = 1'b0;
  logic       m_wrst = 1'b1;
  logic [7:0] pa = 8'd0;
  logic [7:0] pb = 8'd250;
  logic [7:0] m_burst = 8'd0;
  logic [7:0] m_rej = 8'd0;
  logic [3:0] m_leds = 4'd0;
  int         m_wc = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int occ = 0;
  int depth = 16;
  bit auto_fl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] p, input logic [7:0] s, input logic [7:0] e);
    return (p == e) ? s : p + 8'd1;
  endfunction

  task automatic upd_flags();
    if (auto_fl) begin
      full_flag  = (occ >= depth);
      empty_flag = (occ == 0);
    end
  endtask

  // One clock: predict from the inputs in force, then compare after the edge.
  task automatic tick();
    logic acc;
    logic [7:0] obs_a, obs_b, ea, eb;
    acc = m_we && !full_flag && !rst;
    obs_a = wr_data_a;
    obs_b = wr_data_b;
    if (acc) begin
      qa.push_back(pa);
      qb.push_back(pb);
    end
    if (rst) begin
      m_st = 0; m_rc = 0; m_we = 1'b0; m_wrst = 1'b1;
      pa = 8'd0; pb = 8'd250;
      m_burst = 8'd0; m_rej = 8'd0; m_leds = 4'd0; m_wc = 0;
    end else begin
      if (acc) begin
        pa = nxt(pa, 8'd0, 8'd255);
        pb = nxt(pb, 8'd250, 8'd255);
        if (m_wc == CNT - 1) begin
          m_wc = 0;
          m_leds = m_leds + 4'd1;
        end else begin
          m_wc++;
        end
      end
      if (m_we && full_flag && m_rej != 8'd255) m_rej = m_rej + 8'd1;
      case (m_st)
        0: if (m_rc == WC) begin m_st = 1; m_wrst = 1'b0; end else m_rc++;
        1: if (en && empty_flag && !full_flag) begin
             m_st = 2; m_we = 1'b1; m_burst = m_burst + 8'd1;
           end
        default: if (full_flag || !en) begin m_st = 1; m_we = 1'b0; end
      endcase
    end
    @(posedge clk);
    #1;
    if (acc) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("accepted_word_a", obs_a, ea);
      chk("accepted_word_b", obs_b, eb);
      occ++;
    end
    chk("we_a", we_a, m_we);
    chk("we_b", we_b, m_we);
    chk("wrst_a", wrst_a, m_wrst);
    chk("wrst_b", wrst_b, m_wrst);
    chk("wr_data_a", wr_data_a, pa);
    chk("wr_data_b", wr_data_b, pb);
    chk("burst_cnt", burst_a, m_burst);
    chk("cnt_leds", leds_a, m_leds);
    chk("rej_cnt", rej_a, m_rej);
    upd_flags();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; full_flag = 1'b0; empty_flag = 1'b1;

    // Reset and write-side reset pulse
    repeat (3) tick();
    chk("reset_wrst", wrst_a, 1);
    chk("reset_we", we_a, 0);
    chk("reset_data_b", wr_data_b, 250);
    rst = 1'b0;
    repeat (WC) tick();
    chk("wrst_held_4", wrst_a, 1);
    tick();
    chk("wrst_released", wrst_a, 0);

    // Empty -> fill -> full hysteresis with a 16-deep FIFO
    en = 1'b1; auto_fl = 1'b1; occ = 0; upd_flags();
    tick();
    chk("we_rise_after_empty", we_a, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 5)  chk("leds_after_5", leds_a, 1);
      if (i == 10) chk("leds_after_10", leds_a, 2);
    end
    chk("data_at_full", wr_data_a, 16);
    tick();
    chk("rej_after_fill", rej_a, 1);
    chk("data_held", wr_data_a, 16);
    chk("we_after_full", we_a, 0);
    chk("burst_after_fill", burst_a, 1);
    tick();

    // Both flags set in idle: full wins, no burst
    auto_fl = 1'b0; full_flag = 1'b1; empty_flag = 1'b1;
    repeat (3) tick();
    chk("no_burst_both_flags", burst_a, 1);

    // Enable dropped mid-burst, then resume
    auto_fl = 1'b1; occ = 0; upd_flags();
    repeat (5) tick();
    en = 1'b0;
    tick();
    chk("we_after_en_low", we_a, 0);
    en = 1'b1;
    repeat (2) tick();
    occ = 0; upd_flags();
    tick();
    chk("resume_data", wr_data_a, 21);
    repeat (19) tick();

    // More bursts to carry the LED counter through its wrap at 80 accepts
    for (int b = 0; b < 3; b++) begin
      occ = 0; upd_flags();
      repeat (20) tick();
    end
    chk("leds_wrapped", leds_a, 1);

    // Reject saturation: one rejected cycle per short burst
    auto_fl = 1'b0;
    for (int i = 0; i < 260; i++) begin
      empty_flag = 1'b1; full_flag = 1'b0;
      tick();
      full_flag = 1'b1;
      tick();
    end
    chk("rej_saturated", rej_a, 255);

    // Reset mid-burst
    empty_flag = 1'b1; full_flag = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_we", we_a, 0);
    chk("midrst_wrst", wrst_a, 1);
    chk("midrst_data", wr_data_a, 0);
    chk("midrst_burst", burst_a, 0);
    chk("midrst_rej", rej_a, 0);
    chk("midrst_leds", leds_a, 0);
    rst = 1'b0;
    repeat (WC + 1) tick();
    chk("midrst_wrst_released", wrst_a, 0);
    auto_fl = 1'b1; occ = 0; upd_flags();
    repeat (8) tick();
    chk("leds_after_rst_block", leds_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
